// File: rtl/instruc_loader.sv
// UART byte-stream instruction loader: packs four bytes MSB-first into a word
// and writes it to instruction memory until HALT_WORD or capacity is reached.
module instruc_loader #(
  parameter int NB_INST = 32,
  parameter int NB_ADDR = 32,
  parameter int N_WORDS = 64,
  parameter logic [NB_INST-1:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic clk,
  input  logic reset,
  input  logic i_start,
  input  logic rx_done_tick,
  input  logic [7:0] i_rx_data,
  output logic o_wr_en,
  output logic [NB_ADDR-1:0] o_wr_addr,
  output logic [NB_INST-1:0] o_wr_data,
  output logic o_busy,
  output logic o_done,
  output logic o_overflow,
  output logic [$clog2(N_WORDS):0] o_word_count
);

  localparam int CW = $clog2(N_WORDS) + 1;
  localparam int AW = CW + 2;
  localparam logic [CW-1:0] CAP = CW'(N_WORDS);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE
  } state_t;

  state_t state, state_next;

  logic [NB_INST-1:0] shift_q;
  logic [NB_INST-1:0] word;
  logic [1:0] idx;
  logic [CW-1:0] count;
  logic [CW-1:0] count_inc;
  logic accept;
  logic word_full;
  logic is_halt;
  logic cap_hit;
  logic [NB_ADDR+AW-1:0] addr_ext;

  // i_start wins over a coincident tick
  assign accept = (state == LOAD) && rx_done_tick && !i_start;
  assign word = {shift_q[NB_INST-9:0], i_rx_data};
  assign word_full = accept && (idx == 2'd3);
  assign count_inc = count + CW'(1);
  assign is_halt = (word == HALT_WORD);
  assign cap_hit = (count_inc == CAP);
  assign addr_ext = {{NB_ADDR{1'b0}}, count, 2'b00};

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (i_start) state_next = LOAD;
      end
      LOAD: begin
        if (i_start) begin
          state_next = LOAD;
        end else if (word_full && (is_halt || cap_hit)) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (i_start) state_next = LOAD;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q <= '0;
      idx <= '0;
      count <= '0;
      o_wr_en <= 1'b0;
      o_wr_addr <= '0;
      o_wr_data <= '0;
      o_done <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      o_wr_en <= 1'b0;
      if (i_start) begin
        shift_q <= '0;
        idx <= '0;
        count <= '0;
        o_done <= 1'b0;
        o_overflow <= 1'b0;
      end else if (accept) begin
        shift_q <= word;
        idx <= idx + 2'd1;
        if (idx == 2'd3) begin
          o_wr_en <= 1'b1;
          o_wr_data <= word;
          o_wr_addr <= addr_ext[NB_ADDR-1:0];
          count <= count_inc;
          if (is_halt) begin
            o_done <= 1'b1;
          end else if (cap_hit) begin
            o_done <= 1'b1;
            o_overflow <= 1'b1;
          end
        end
      end
    end
  end

  assign o_busy = (state == LOAD);
  assign o_word_count = count;

endmodule

// File: tb/tb_instruc_loader.sv
// Scoreboard bench for instruc_loader: a byte-stream model predicts writes,
// a negedge monitor pops and compares every write strobe.
module tb_instruc_loader;

  localparam int NW = 4;
  localparam int CWB = $clog2(NW) + 1;
  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  logic clk = 1'b0;
  logic reset;
  logic i_start;
  logic rx_done_tick;
  logic [7:0] i_rx_data;
  logic o_wr_en;
  logic [31:0] o_wr_addr;
  logic [31:0] o_wr_data;
  logic o_busy;
  logic o_done;
  logic o_overflow;
  logic [CWB-1:0] o_word_count;

  instruc_loader #(
    .NB_INST(32),
    .NB_ADDR(32),
    .N_WORDS(NW),
    .HALT_WORD(HALT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .i_start(i_start),
    .rx_done_tick(rx_done_tick),
    .i_rx_data(i_rx_data),
    .o_wr_en(o_wr_en),
    .o_wr_addr(o_wr_addr),
    .o_wr_data(o_wr_data),
    .o_busy(o_busy),
    .o_done(o_done),
    .o_overflow(o_overflow),
    .o_word_count(o_word_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int tests = 0;
  int fails = 0;
  logic exp_done;
  logic exp_ovf;
  int exp_cnt;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && o_wr_en) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: addr %0h data %0h, none expected",
                 o_wr_addr, o_wr_data);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_addr", 64'(o_wr_addr), 64'(e.addr));
        chk("wr_data", 64'(o_wr_data), 64'(e.data));
      end
    end
  end

  // Reference: whole words from the byte stream, stop at halt or capacity
  task automatic model(input logic [7:0] b[$]);
    logic [31:0] w;
    wr_t e;
    exp_done = 1'b0;
    exp_ovf = 1'b0;
    exp_cnt = 0;
    for (int i = 0; i + 3 < b.size(); i += 4) begin
      if (exp_done) break;
      w = {b[i], b[i+1], b[i+2], b[i+3]};
      e.addr = 32'(exp_cnt * 4);
      e.data = w;
      exp_q.push_back(e);
      exp_cnt++;
      if (w == HALT) exp_done = 1'b1;
      else if (exp_cnt == NW) begin
        exp_done = 1'b1;
        exp_ovf = 1'b1;
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic with_tick, input logic [7:0] b);
    i_start = 1'b1;
    rx_done_tick = with_tick;
    i_rx_data = b;
    cyc();
    i_start = 1'b0;
    rx_done_tick = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    rx_done_tick = 1'b1;
    i_rx_data = b;
    cyc();
    rx_done_tick = 1'b0;
    repeat (gap) cyc();
  endtask

  task automatic run_load(input logic [7:0] b[$], input int gmax,
                          input string tag);
    model(b);
    pulse_start(1'b0, 8'h00);
    foreach (b[i]) send(b[i], (gmax < 0) ? 0 : $urandom_range(gmax, 0));
    repeat (3) cyc();
  endtask

  task automatic check_end(input string tag);
    chk({tag, "_drain"}, 64'(exp_q.size()), 64'd0);
    chk({tag, "_done"}, 64'(o_done), 64'(exp_done));
    chk({tag, "_ovf"}, 64'(o_overflow), 64'(exp_ovf));
    chk({tag, "_cnt"}, 64'(o_word_count), 64'(exp_cnt));
    chk({tag, "_busy"}, 64'(o_busy), 64'(!exp_done));
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_wr_en"}, 64'(o_wr_en), 64'd0);
    chk({tag, "_wr_addr"}, 64'(o_wr_addr), 64'd0);
    chk({tag, "_wr_data"}, 64'(o_wr_data), 64'd0);
    chk({tag, "_busy"}, 64'(o_busy), 64'd0);
    chk({tag, "_done"}, 64'(o_done), 64'd0);
    chk({tag, "_ovf"}, 64'(o_overflow), 64'd0);
    chk({tag, "_cnt"}, 64'(o_word_count), 64'd0);
  endtask

  initial begin
    logic [7:0] b[$];
    reset = 1'b1;
    i_start = 1'b0;
    rx_done_tick = 1'b0;
    i_rx_data = 8'h00;
    repeat (3) cyc();
    check_reset_vals("rst");
    reset = 1'b0;
    cyc();
    send(8'h12, 0);
    cyc();
    chk("idle_ignore_busy", 64'(o_busy), 64'd0);
    chk("idle_ignore_cnt", 64'(o_word_count), 64'd0);

    b = '{8'h20, 8'h01, 8'h00, 8'h05};
    run_load(b, 1, "basic");
    check_end("basic");

    b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
          8'h01, 8'h02, 8'h03, 8'h04};
    run_load(b, 0, "halt");
    check_end("halt");

    b = {};
    for (int i = 0; i < 17; i++) b.push_back(8'(i + 1));
    run_load(b, -1, "ovf");
    check_end("ovf");

    b = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hB1, 8'hB2, 8'hB3, 8'hB4};
    run_load(b, -1, "b2b");
    check_end("b2b");

    pulse_start(1'b0, 8'h00);
    send(8'h55, 0);
    send(8'h66, 1);
    b = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    run_load(b, 1, "restart");
    check_end("restart");

    model(b);
    pulse_start(1'b1, 8'h77);
    foreach (b[i]) send(b[i], 0);
    repeat (3) cyc();
    check_end("start_tick");

    pulse_start(1'b0, 8'h00);
    send(8'h01, 0);
    send(8'h02, 0);
    send(8'h03, 0);
    reset = 1'b1;
    i_start = 1'b1;
    cyc();
    reset = 1'b0;
    i_start = 1'b0;
    send(8'h04, 0);
    repeat (3) cyc();
    check_reset_vals("rst_mid");
    chk("rst_mid_drain", 64'(exp_q.size()), 64'd0);

    for (int it = 0; it < 40; it++) begin
      int n;
      n = $urandom_range(20, 0);
      b = {};
      for (int k = 0; k < n; k++) begin
        if ((k % 4 == 0) && ($urandom_range(7, 0) == 0)) begin
          repeat (4) b.push_back(8'hFF);
          k += 3;
        end else begin
          b.push_back(8'($urandom_range(255, 0)));
        end
      end
      run_load(b, 2, "rand");
      check_end("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
